// File: rtl/weight_load_ctrl.sv
// Weight load controller: clears NUM_REGS downstream weight registers, then writes one streamed weight per slot.
// Optional build macro WLOAD_SKIP_ZERO_EN: zero weights consume a slot without raising a write enable.
module weight_load_ctrl #(
    parameter int F_WIDTH  = 8,
    parameter int NUM_REGS = 9
) (
    input  logic                       clk_i,
    input  logic                       wctl_rst_i,
    input  logic                       start_i,
    input  logic signed [F_WIDTH-1:0]  f_weight_i,
    input  logic                       f_valid_i,
    output logic                       f_ready_o,
    output logic signed [F_WIDTH-1:0]  f_weight_o,
    output logic                       wreg_rst_o,
    output logic [NUM_REGS-1:0]        wreg_wr_en_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [1:0]                 dbg_state
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(NUM_REGS - 1);
    localparam logic [NUM_REGS-1:0] ONE_HOT0 = NUM_REGS'(1);

`ifdef WLOAD_SKIP_ZERO_EN
    localparam bit SKIP_ZERO = 1'b1;
`else
    localparam bit SKIP_ZERO = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        LOAD  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             handshake;
    logic             write_slot;

    // Weight stream handshake: a weight transfers on every rising edge where
    // f_valid_i and f_ready_o are both high; the source holds f_weight_i
    // stable while f_valid_i is high and f_ready_o is low. No timeout.
    assign f_ready_o  = (state == LOAD);
    assign handshake  = f_valid_i & f_ready_o;
    assign busy_o     = (state == CLEAR) || (state == LOAD);
    assign dbg_state  = state;
    assign write_slot = !SKIP_ZERO || (f_weight_i != '0);

    always_ff @(posedge clk_i) begin
        if (wctl_rst_i) begin
            state        <= IDLE;
            idx          <= '0;
            f_weight_o   <= '0;
            wreg_rst_o   <= 1'b0;
            wreg_wr_en_o <= '0;
            done_o       <= 1'b0;
        end else begin
            // Pulse outputs default low so each lasts exactly one cycle.
            wreg_rst_o   <= 1'b0;
            wreg_wr_en_o <= '0;
            done_o       <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state      <= CLEAR;
                        idx        <= '0;
                        wreg_rst_o <= 1'b1;
                    end
                end
                CLEAR: begin
                    state <= LOAD;
                end
                LOAD: begin
                    if (handshake) begin
                        f_weight_o <= f_weight_i;
                        if (write_slot) begin
                            wreg_wr_en_o <= ONE_HOT0 << idx;
                        end
                        // The last slot's enable and done_o land in the same cycle.
                        if (idx == LAST_IDX) begin
                            state  <= DONE;
                            idx    <= '0;
                            done_o <= 1'b1;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_weight_load_ctrl.sv
// Self-checking bench for weight_load_ctrl: directed scenarios plus a write-enable scoreboard.
module tb_weight_load_ctrl;

  localparam int F_WIDTH  = 8;
  localparam int NUM_REGS = 9;
  localparam int SB_W     = NUM_REGS + F_WIDTH;

`ifdef WLOAD_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic                      clk_i = 1'b0;
  logic                      wctl_rst_i;
  logic                      start_i;
  logic signed [F_WIDTH-1:0] f_weight_i;
  logic                      f_valid_i;
  logic                      f_ready_o;
  logic signed [F_WIDTH-1:0] f_weight_o;
  logic                      wreg_rst_o;
  logic [NUM_REGS-1:0]       wreg_wr_en_o;
  logic                      busy_o;
  logic                      done_o;
  logic [1:0]                dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  logic [SB_W-1:0] exp_q[$];

  weight_load_ctrl #(.F_WIDTH(F_WIDTH), .NUM_REGS(NUM_REGS)) dut (
    .clk_i(clk_i),
    .wctl_rst_i(wctl_rst_i),
    .start_i(start_i),
    .f_weight_i(f_weight_i),
    .f_valid_i(f_valid_i),
    .f_ready_o(f_ready_o),
    .f_weight_o(f_weight_o),
    .wreg_rst_o(wreg_rst_o),
    .wreg_wr_en_o(wreg_wr_en_o),
    .busy_o(busy_o),
    .done_o(done_o),
    .dbg_state(dbg_state)
  );

  // clock / cycle counter
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic logic [NUM_REGS-1:0] onehot(input int slot);
    logic [NUM_REGS-1:0] v;
    v = '0;
    v[slot] = 1'b1;
    return v;
  endfunction

  function automatic logic [NUM_REGS-1:0] exp_en(input logic signed [F_WIDTH-1:0] w, input int slot);
    if (SKIP && (w == 0)) return '0;
    return onehot(slot);
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // scoreboard monitor: every write enable must match the oldest expected write
  always @(posedge clk_i) begin
    logic [SB_W-1:0] got;
    logic [SB_W-1:0] exp;
    #2;
    n_checks++;
    if (($countones(wreg_wr_en_o) > 1) || (wreg_rst_o && (wreg_wr_en_o != '0)))
      $display("FAIL wr_en_exclusive: wr_en=%h wreg_rst=%b required onehot0 and not with clear", wreg_wr_en_o, wreg_rst_o);
    else
      n_pass++;
    if (wreg_wr_en_o !== '0) begin
      n_checks++;
      got = {wreg_wr_en_o, f_weight_o};
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected_write: wr_en=%h weight=%0d required no write", wreg_wr_en_o, f_weight_o);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp)
          $display("FAIL sb_write: got {en,w}=%h required %h", got, exp);
        else
          n_pass++;
      end
    end
  end

  // driver tasks
  task automatic start_load();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
  endtask

  task automatic send_weight(input logic signed [F_WIDTH-1:0] w, input int slot);
    int t;
    f_weight_i = w;
    f_valid_i  = 1'b1;
    if (exp_en(w, slot) != '0) exp_q.push_back({onehot(slot), w});
    t = 0;
    while ((f_ready_o !== 1'b1) && (t < 20)) begin
      tick();
      t++;
    end
    n_checks++;
    if (t >= 20) $display("FAIL ready_timeout: f_ready_o=%b required 1 within 20 cycles", f_ready_o);
    else n_pass++;
    tick();
  endtask

  task automatic run_slots(input int first, input int last);
    logic signed [F_WIDTH-1:0] w;
    for (int s = first; s <= last; s++) begin
      w = F_WIDTH'($urandom_range(1, 100));
      send_weight(w, s);
    end
    f_valid_i = 1'b0;
    tick();
  endtask

  // scenarios
  task automatic test_reset();
    wctl_rst_i = 1'b1;
    start_i    = 1'b1;
    f_valid_i  = 1'b1;
    f_weight_i = 8'sd17;
    tick(); tick(); tick();
    n_checks++;
    if ({f_weight_o, wreg_wr_en_o, wreg_rst_o, done_o, busy_o, f_ready_o, dbg_state} !== '0)
      $display("FAIL reset_outputs: w=%0d en=%h clr=%b done=%b busy=%b rdy=%b st=%0d required all 0",
               f_weight_o, wreg_wr_en_o, wreg_rst_o, done_o, busy_o, f_ready_o, dbg_state);
    else n_pass++;
    wctl_rst_i = 1'b0;
    start_i    = 1'b0;
    f_valid_i  = 1'b0;
    tick();
    n_checks++;
    if ((dbg_state !== 2'd0) || (busy_o !== 1'b0)) $display("FAIL reset_idle: st=%0d busy=%b required 0/0", dbg_state, busy_o);
    else n_pass++;
  endtask

  task automatic test_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    n_checks++;
    if ({busy_o, wreg_rst_o, f_ready_o, wreg_wr_en_o} !== {1'b1, 1'b1, 1'b0, {NUM_REGS{1'b0}}})
      $display("FAIL start_clear: busy=%b clr=%b rdy=%b en=%h required 1 1 0 0", busy_o, wreg_rst_o, f_ready_o, wreg_wr_en_o);
    else n_pass++;
    tick();
    n_checks++;
    if ({busy_o, wreg_rst_o, f_ready_o} !== 3'b101)
      $display("FAIL start_load: busy=%b clr=%b rdy=%b required 1 0 1", busy_o, wreg_rst_o, f_ready_o);
    else n_pass++;
    run_slots(0, NUM_REGS - 1);
  endtask

  task automatic test_back_to_back();
    int wts[NUM_REGS] = '{-4, 1, 2, 3, 4, 5, 6, 7, 8};
    int c_first;
    logic signed [F_WIDTH-1:0] w;
    c_first = 0;
    start_load();
    for (int s = 0; s < NUM_REGS; s++) begin
      w = F_WIDTH'(wts[s]);
      send_weight(w, s);
      if (s == 0) c_first = cyc;
      n_checks++;
      if ((f_weight_o !== w) || (wreg_wr_en_o !== onehot(s)) || (done_o !== (s == NUM_REGS - 1)))
        $display("FAIL b2b_slot%0d: w=%0d en=%h done=%b required w=%0d en=%h done=%b",
                 s, f_weight_o, wreg_wr_en_o, done_o, w, onehot(s), (s == NUM_REGS - 1));
      else n_pass++;
    end
    n_checks++;
    if (cyc - c_first !== NUM_REGS - 1) $display("FAIL b2b_consecutive: span=%0d required %0d", cyc - c_first, NUM_REGS - 1);
    else n_pass++;
    f_valid_i = 1'b0;
    tick();
    n_checks++;
    if ({done_o, busy_o, dbg_state} !== 4'b0000) $display("FAIL b2b_idle: done=%b busy=%b st=%0d required 0 0 0", done_o, busy_o, dbg_state);
    else n_pass++;
  endtask

  task automatic test_stall();
    logic signed [F_WIDTH-1:0] w3;
    int bad;
    start_load();
    send_weight(8'sd11, 0);
    send_weight(-8'sd22, 1);
    w3 = -8'sd33;
    send_weight(w3, 2);
    f_valid_i  = 1'b0;
    f_weight_i = 8'sd99;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if ((wreg_wr_en_o !== '0) || (f_weight_o !== w3)) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL stall_hold: %0d bad cycles, en=%h w=%0d required en=0 w=%0d", bad, wreg_wr_en_o, f_weight_o, w3);
    else n_pass++;
    send_weight(8'sd44, 3);
    n_checks++;
    if (wreg_wr_en_o !== onehot(3)) $display("FAIL stall_resume: en=%h required %h", wreg_wr_en_o, onehot(3));
    else n_pass++;
    run_slots(4, NUM_REGS - 1);
  endtask

  task automatic test_reset_mid_load();
    int bad;
    start_load();
    for (int s = 0; s < 4; s++) send_weight(F_WIDTH'(s + 1), s);
    wctl_rst_i = 1'b1;
    f_weight_i = 8'sd55;
    start_i    = 1'b1;
    tick();
    n_checks++;
    if ({f_weight_o, wreg_wr_en_o, wreg_rst_o, done_o, busy_o, f_ready_o, dbg_state} !== '0)
      $display("FAIL midrst_outputs: w=%0d en=%h clr=%b done=%b busy=%b rdy=%b st=%0d required all 0",
               f_weight_o, wreg_wr_en_o, wreg_rst_o, done_o, busy_o, f_ready_o, dbg_state);
    else n_pass++;
    wctl_rst_i = 1'b0;
    start_i    = 1'b0;
    f_valid_i  = 1'b0;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if ((wreg_wr_en_o !== '0) || (busy_o !== 1'b0)) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL midrst_quiet: %0d cycles with en=%h busy=%b required 0", bad, wreg_wr_en_o, busy_o);
    else n_pass++;
    start_load();
    send_weight(8'sd9, 0);
    n_checks++;
    if (wreg_wr_en_o !== onehot(0)) $display("FAIL midrst_restart: en=%h required %h", wreg_wr_en_o, onehot(0));
    else n_pass++;
    run_slots(1, NUM_REGS - 1);
  endtask

  task automatic test_zero_weights();
    int wts[3] = '{0, 5, 0};
    logic signed [F_WIDTH-1:0] w;
    start_load();
    for (int s = 0; s < 3; s++) begin
      w = F_WIDTH'(wts[s]);
      send_weight(w, s);
      n_checks++;
      if ((wreg_wr_en_o !== exp_en(w, s)) || (f_weight_o !== w))
        $display("FAIL zero_slot%0d: en=%h w=%0d required en=%h w=%0d", s, wreg_wr_en_o, f_weight_o, exp_en(w, s), w);
      else n_pass++;
    end
    run_slots(3, NUM_REGS - 1);
  endtask

  task automatic test_start_ignored();
    int clears;
    start_load();
    start_i = 1'b1;
    run_slots(0, NUM_REGS - 2);
    send_weight(8'sd7, NUM_REGS - 1);
    f_valid_i = 1'b0;
    n_checks++;
    if ({done_o, dbg_state} !== {1'b1, 2'd3}) $display("FAIL ign_done: done=%b st=%0d required 1 3", done_o, dbg_state);
    else n_pass++;
    tick();
    start_i = 1'b0;
    n_checks++;
    if ({busy_o, wreg_rst_o, dbg_state} !== 4'b0000) $display("FAIL ign_after_done: busy=%b clr=%b st=%0d required 0 0 0", busy_o, wreg_rst_o, dbg_state);
    else n_pass++;
    tick();
    n_checks++;
    if ({busy_o, dbg_state} !== 3'b000) $display("FAIL ign_idle: busy=%b st=%0d required 0 0", busy_o, dbg_state);
    else n_pass++;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    clears = 0;
    for (int i = 0; i < 5; i++) begin
      if (wreg_rst_o === 1'b1) clears++;
      tick();
    end
    n_checks++;
    if (clears != 1) $display("FAIL ign_single_clear: clears=%0d required 1", clears);
    else n_pass++;
    wctl_rst_i = 1'b1;
    tick();
    wctl_rst_i = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic signed [F_WIDTH-1:0] w;
    int gap;
    start_load();
    for (int s = 0; s < NUM_REGS; s++) begin
      gap = $urandom_range(0, 3);
      f_valid_i = 1'b0;
      for (int g = 0; g < gap; g++) tick();
      w = F_WIDTH'($urandom_range(0, 255));
      send_weight(w, s);
    end
    f_valid_i = 1'b0;
    n_checks++;
    if (done_o !== 1'b1) $display("FAIL rand_done: done=%b required 1", done_o);
    else n_pass++;
    tick();
  endtask

  initial begin
    wctl_rst_i = 1'b1;
    start_i    = 1'b0;
    f_valid_i  = 1'b0;
    f_weight_i = '0;
    test_reset();
    test_start();
    test_back_to_back();
    test_stall();
    test_reset_mid_load();
    test_zero_weights();
    test_start_ignored();
    for (int r = 0; r < 4; r++) test_random();
    tick();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL sb_drain: %0d writes outstanding required 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
